fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64: number of 2-bit counters; power of two, at least 4.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr  output  32  fetch address, equal to the current PC.
REQ-006 SHALL have port imem_rdata  input  32  instruction at imem_addr, combinational read.
REQ-007 SHALL have port ID_Stall  input  1  hold PC and IF/ID register.
REQ-008 SHALL have port flush  input  1  squash IF/ID and redirect fetch.
REQ-009 SHALL have port ID_RedirectPC  input  32  correct next PC when flush=1.
REQ-010 SHALL have port ID_AttemptBranch  input  1  conditional branch resolved in ID this cycle.
REQ-011 SHALL have port ID_BranchTaken  input  1  resolved outcome of that branch.
REQ-012 SHALL have ports ID_Instr, ID_PC, ID_PCPlus4  output  32 each  IF/ID register contents.
REQ-013 SHALL have port ID_PredictBranchTaken  output  1  IF predicted redirect for ID_Instr.
REQ-014 SHALL have port ID_Valid  output  1  ID_Instr is a real instruction, not a bubble.

Function
REQ-015 SHALL pre-decode imem_rdata each cycle: B-type is opcode 7'b1100011; JAL is 7'b1101111.
REQ-016 SHALL predict taken for B-type when BHT counter[1]=1, and always for JAL; the predicted next PC SHALL be PC plus the sign-extended B or J immediate.
REQ-017 SHALL use PC+4 as next PC when not predicting taken; all PC arithmetic is 32-bit modulo with no overflow flag.
REQ-018 SHALL index the BHT by PC[log2(BHT_ENTRIES)+1:2] for reads and by ID_PC with the same bits for updates.
REQ-019 SHALL, on ID_AttemptBranch=1 and ID_Stall=0, increment the indexed counter if ID_BranchTaken=1 (saturating at 3) and decrement it otherwise (saturating at 0).
REQ-020 SHALL return the pre-update counter value when a read and an update hit the same index in the same cycle (no bypass).
REQ-021 SHALL apply the following priority at each clock edge:
- flush: PC <= ID_RedirectPC; IF/ID <= bubble (ID_Instr=32'h0000_0013, ID_Valid=0, ID_PredictBranchTaken=0).
- else ID_Stall: PC and IF/ID hold.
- else: PC <= predicted next PC; IF/ID <= {imem_rdata, PC, PC+4, prediction}, ID_Valid=1.
REQ-022 SHALL let flush override ID_Stall when both are 1; the BHT update of REQ-019 is still gated by ID_Stall only.
REQ-023 SHALL have a fetch-to-ID latency of exactly 1 cycle; a redirect on flush SHALL take effect in the fetch on the following cycle.

Reset
REQ-024 SHALL, while rst=0, force PC=RESET_PC, IF/ID to the bubble of REQ-021, and every BHT counter to 2'b01 (weakly not-taken), asynchronously.
REQ-025 SHALL abandon any prediction in flight on reset mid-operation and restart fetch from RESET_PC on the first edge after rst rises.

Configuration
REQ-026 SHALL use macro FETCH_BHT_EN to select the predictor:
- Defined: the BHT drives B-type prediction as described above.
- Undefined: no BHT storage is built, B-type predicts not-taken, JAL still predicts taken, and ID_AttemptBranch/ID_BranchTaken are ignored.

Structure
REQ-027 SHALL place the opcode constants, the NOP constant 32'h0000_0013, and a 2-bit counter typedef in shared package rv_pkg.
REQ-028 SHALL implement the counter array in sub-module branch_history_table (one read port, one write port), instantiated only under FETCH_BHT_EN.

Verification
REQ-029 SHALL verify reset: rst=0 then released with imem returning NOP -> imem_addr 0, 4, 8 on successive cycles; ID_Valid=0 in the first cycle after release.
REQ-030 SHALL verify JAL prediction: JAL imm=+16 at PC 0x8 -> next imem_addr=0x18 and ID_PredictBranchTaken=1 with ID_PC=0x8.
REQ-031 SHALL verify BHT training: two resolved taken updates (ID_BranchTaken=1) for PC 0x20 -> counter=3; then the B-type at 0x20 with imm=-8 is predicted taken and the next imem_addr=0x18.
REQ-032 SHALL verify stall: ID_Stall=1 for 2 cycles -> imem_addr, ID_Instr and ID_PC stay constant, and no BHT change occurs despite ID_AttemptBranch=1.
REQ-033 SHALL verify flush over stall: flush=1 and ID_Stall=1 with ID_RedirectPC=0x100 -> next imem_addr=0x100 and ID_Instr=32'h0000_0013 with ID_Valid=0.
REQ-034 SHALL verify saturation: four not-taken updates from reset -> counter=0 with no wrap to 3, and a B-type is predicted not-taken.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V fetch constants, counter type and immediate helpers
package rv_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef logic [1:0] bht_ctr_t;

    // Weakly not-taken: a single taken outcome flips the prediction.
    localparam bht_ctr_t CTR_RESET = 2'b01;

    // Sign-extended B-type immediate.
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // Sign-extended J-type immediate.
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Saturating 2-bit counter step.
    function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating counter array, one read and one write port
module branch_history_table
    import rv_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    localparam int unsigned IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_ctr_t         rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_ctr_t ctr [ENTRIES];

    // Counter array: all entries return to weakly not-taken on reset, one update per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        end
    end

    // Read is asynchronous and sees the pre-update value on a same-index write.
    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage with JAL/branch prediction and IF/ID register; FETCH_BHT_EN enables the BHT
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        ID_Stall,
    input  logic        flush,
    input  logic [31:0] ID_RedirectPC,
    input  logic        ID_AttemptBranch,
    input  logic        ID_BranchTaken,
    output logic [31:0] ID_Instr,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PCPlus4,
    output logic        ID_PredictBranchTaken,
    output logic        ID_Valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pred_target;
    logic [31:0] next_pc;
    logic        is_branch;
    logic        is_jal;
    logic        bht_taken;
    logic        pred_taken;

`ifdef FETCH_BHT_EN
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t bht_ctr;

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc[IDX_W+1:2]),
        .rd_ctr   (bht_ctr),
        .wr_en    (ID_AttemptBranch & ~ID_Stall),
        .wr_idx   (ID_PC[IDX_W+1:2]),
        .wr_taken (ID_BranchTaken)
    );

    assign bht_taken = bht_ctr[1];
`else
    localparam int unsigned unused_bht_entries = BHT_ENTRIES;
    logic unused_bht_inputs;

    assign unused_bht_inputs = ID_AttemptBranch ^ ID_BranchTaken;
    assign bht_taken         = 1'b0;
`endif

    assign imem_addr = pc;

    // Pre-decode and next-PC selection for the instruction being fetched.
    always_comb begin
        is_branch   = (imem_rdata[6:0] == OPC_BRANCH);
        is_jal      = (imem_rdata[6:0] == OPC_JAL);
        pc_plus4    = pc + 32'd4;
        pred_taken  = is_jal | (is_branch & bht_taken);
        pred_target = pc + (is_jal ? imm_j(imem_rdata) : imm_b(imem_rdata));
        next_pc     = pred_taken ? pred_target : pc_plus4;
    end

    // PC and IF/ID register: flush beats stall, stall holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc                    <= RESET_PC;
            ID_Instr              <= NOP_INSTR;
            ID_PC                 <= '0;
            ID_PCPlus4            <= '0;
            ID_PredictBranchTaken <= 1'b0;
            ID_Valid              <= 1'b0;
        end else if (flush) begin
            pc                    <= ID_RedirectPC;
            ID_Instr              <= NOP_INSTR;
            ID_PredictBranchTaken <= 1'b0;
            ID_Valid              <= 1'b0;
        end else if (!ID_Stall) begin
            pc                    <= next_pc;
            ID_Instr              <= imem_rdata;
            ID_PC                 <= pc;
            ID_PCPlus4            <= pc_plus4;
            ID_PredictBranchTaken <= pred_taken;
            ID_Valid              <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] JAL16 = 32'h0100_006F;
    localparam logic [31:0] BEQM8 = 32'hFE00_0CE3;
`ifdef FETCH_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ID_Stall;
    logic        flush;
    logic [31:0] ID_RedirectPC;
    logic        ID_AttemptBranch;
    logic        ID_BranchTaken;
    logic [31:0] ID_Instr;
    logic [31:0] ID_PC;
    logic [31:0] ID_PCPlus4;
    logic        ID_PredictBranchTaken;
    logic        ID_Valid;

    logic [31:0] imem [0:127];

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .BHT_ENTRIES (64)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem_addr             (imem_addr),
        .imem_rdata            (imem_rdata),
        .ID_Stall              (ID_Stall),
        .flush                 (flush),
        .ID_RedirectPC         (ID_RedirectPC),
        .ID_AttemptBranch      (ID_AttemptBranch),
        .ID_BranchTaken        (ID_BranchTaken),
        .ID_Instr              (ID_Instr),
        .ID_PC                 (ID_PC),
        .ID_PCPlus4            (ID_PCPlus4),
        .ID_PredictBranchTaken (ID_PredictBranchTaken),
        .ID_Valid              (ID_Valid)
    );

    assign imem_rdata = imem[imem_addr[8:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        chk_pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t  exp_q [$];
    string nm_q [$];
    int    passed = 0;
    int    total  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    task automatic expect_at(input int off, input string nm, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc, input logic chk_pc,
                             input logic [31:0] instr, input logic pred);
        exp_t e;
        e.cyc = cyc + off; e.addr = addr; e.valid = valid; e.pc = pc;
        e.chk_pc = chk_pc; e.instr = instr; e.pred = pred;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic bubble(input int off, input string nm, input logic [31:0] addr);
        expect_at(off, nm, addr, 1'b0, 32'h0, 1'b0, NOP_INSTR, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        ID_Stall = 1'b0; flush = 1'b0; ID_RedirectPC = 32'h0;
        ID_AttemptBranch = 1'b0; ID_BranchTaken = 1'b0;
    endtask

    // Flush back to target while optionally resolving the branch held in ID.
    task automatic redirect_update(input logic upd, input logic taken, input logic [31:0] target);
        ID_AttemptBranch = upd; ID_BranchTaken = taken;
        flush = 1'b1; ID_RedirectPC = target;
        bubble(1, "redirect", target);
        step();
        clear_ctl();
    endtask

    // Fetch the beq -8 at 0x20; taken means next fetch at 0x18.
    task automatic fetch_b20(input string nm, input logic bht_pred);
        logic p;
        p = BHT & bht_pred;
        expect_at(1, nm, p ? 32'h18 : 32'h24, 1'b1, 32'h20, 1'b1, BEQM8, p);
        step();
    endtask

    // Monitor: compare DUT state against every expectation due this cycle.
    always @(negedge clk) begin : mon
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            check({nm, " cycle"}, cyc, e.cyc);
            check({nm, " imem_addr"}, imem_addr, e.addr);
            check({nm, " ID_Valid"}, {31'b0, ID_Valid}, {31'b0, e.valid});
            check({nm, " ID_Instr"}, ID_Instr, e.instr);
            check({nm, " ID_PredictBranchTaken"}, {31'b0, ID_PredictBranchTaken}, {31'b0, e.pred});
            if (e.chk_pc) begin
                check({nm, " ID_PC"}, ID_PC, e.pc);
                check({nm, " ID_PCPlus4"}, ID_PCPlus4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = NOP_INSTR;
        imem[2] = JAL16;
        imem[8] = BEQM8;
        rst = 1'b0;
        clear_ctl();

        step();
        bubble(0, "reset_hold", 32'h0);
        step();
        rst = 1'b1;
        bubble(0, "reset_release", 32'h0);
        expect_at(1, "fetch_0", 32'h4, 1'b1, 32'h0, 1'b1, NOP_INSTR, 1'b0);
        expect_at(2, "fetch_4", 32'h8, 1'b1, 32'h4, 1'b1, NOP_INSTR, 1'b0);
        expect_at(3, "jal_pred", 32'h18, 1'b1, 32'h8, 1'b1, JAL16, 1'b1);
        repeat (3) step();

        expect_at(1, "seq_18", 32'h1C, 1'b1, 32'h18, 1'b1, NOP_INSTR, 1'b0);
        expect_at(2, "seq_1c", 32'h20, 1'b1, 32'h1C, 1'b1, NOP_INSTR, 1'b0);
        expect_at(3, "b_cold", 32'h24, 1'b1, 32'h20, 1'b1, BEQM8, 1'b0);
        repeat (3) step();

        redirect_update(1'b1, 1'b1, 32'h20);
        fetch_b20("b_one_taken", 1'b1);
        redirect_update(1'b1, 1'b1, 32'h20);
        fetch_b20("b_trained", 1'b1);
        redirect_update(1'b1, 1'b0, 32'h20);
        fetch_b20("b_hysteresis", 1'b1);

        ID_Stall = 1'b1; ID_AttemptBranch = 1'b1; ID_BranchTaken = 1'b0;
        expect_at(1, "stall1", BHT ? 32'h18 : 32'h24, 1'b1, 32'h20, 1'b1, BEQM8, BHT);
        expect_at(2, "stall2", BHT ? 32'h18 : 32'h24, 1'b1, 32'h20, 1'b1, BEQM8, BHT);
        repeat (2) step();
        clear_ctl();
        redirect_update(1'b0, 1'b0, 32'h20);
        fetch_b20("b_post_stall", 1'b1);

        flush = 1'b1; ID_Stall = 1'b1; ID_RedirectPC = 32'h100;
        bubble(1, "flush_over_stall", 32'h100);
        step();
        clear_ctl();
        expect_at(1, "after_redirect", 32'h104, 1'b1, 32'h100, 1'b1, NOP_INSTR, 1'b0);
        repeat (2) step();

        rst = 1'b0;
        bubble(0, "async_reset", 32'h0);
        step();
        rst = 1'b1;
        bubble(0, "reset_release2", 32'h0);
        expect_at(1, "restart_fetch", 32'h4, 1'b1, 32'h0, 1'b1, NOP_INSTR, 1'b0);
        step();

        redirect_update(1'b0, 1'b0, 32'h20);
        fetch_b20("b_after_reset", 1'b0);
        for (int k = 0; k < 4; k++) begin
            redirect_update(1'b1, 1'b0, 32'h20);
            fetch_b20("sat_low", 1'b0);
        end
        redirect_update(1'b1, 1'b1, 32'h20);
        fetch_b20("sat_no_wrap", 1'b0);
        redirect_update(1'b1, 1'b1, 32'h20);
        fetch_b20("sat_recover", 1'b1);

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
